// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared types and default constants for the RV32I register file with
// scoreboard (reg_file_sb) and its re-init sequencer (rf_init_seq).
// No ports; imported by the other files of this block.
// -----------------------------------------------------------------------------
package rf_pkg;

  // Register file operating state: sequential re-init, or normal operation.
  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // Default geometry for an RV32I integer file.
  localparam int RF_XLEN    = 32;
  localparam int RF_NREGS   = 32;
  localparam int RF_NREAD   = 2;

  // x2 is the ABI stack pointer; it comes out of re-init pointing at SP_INIT.
  localparam int          RF_SP_IDX  = 2;
  localparam int unsigned RF_SP_INIT = 1024;

endpackage : rf_pkg

// File: rtl/rf_init_seq.sv
// -----------------------------------------------------------------------------
// rf_init_seq
// Re-init sequencer for reg_file_sb. After reset, or on a clr_req pulse, it
// walks every architectural register once (one per cycle), presenting the
// value it must be loaded with, then switches to RUN and raises ready.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   clr_req    in   1-cycle pulse: restart the re-init walk from index 0
//   init_we    out  array write enable owned by the sequencer (INIT state)
//   init_addr  out  register index being initialised
//   init_data  out  value to load (SP_INIT for SP_IDX, else 0)
//   ready      out  1 while in RUN
// -----------------------------------------------------------------------------
module rf_init_seq
  import rf_pkg::*;
#(
  parameter int          XLEN    = RF_XLEN,
  parameter int          NREGS   = RF_NREGS,
  parameter int          SP_IDX  = RF_SP_IDX,
  parameter int unsigned SP_INIT = RF_SP_INIT,
  localparam int         AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_req,
  output logic            init_we,
  output logic [AW-1:0]   init_addr,
  output logic [XLEN-1:0] init_data,
  output logic            ready
);

  // One spare bit on the walk index so the terminal compare against NREGS-1
  // is never ambiguous with a wrapped value.
  localparam int IDX_W = AW + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREGS - 1);
  localparam logic [IDX_W-1:0] IDX_SP   = IDX_W'(SP_IDX);

  rf_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RF_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      RF_INIT: begin
        if (clr_req) begin
          // A request mid-walk restarts the walk; the full NREGS cycles
          // are counted again from the next edge.
          idx_d = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = RF_RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RF_RUN: begin
        if (clr_req) begin
          state_d = RF_INIT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = RF_INIT;
        idx_d   = '0;
      end
    endcase
  end

  // The walk writes the array in every INIT cycle, including the cycle in
  // which a restart is requested; that entry is simply rewritten later.
  assign init_we   = (state_q == RF_INIT);
  assign init_addr = idx_q[AW-1:0];
  assign init_data = (idx_q == IDX_SP) ? XLEN'(SP_INIT) : '0;
  assign ready     = (state_q == RF_RUN);

endmodule : rf_init_seq

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// RV32I integer register file: NREAD combinational read ports, one
// synchronous write port (driven by writeback), same-cycle write-to-read
// bypass, a per-register pending-write scoreboard set at issue and cleared at
// writeback, and a sequential re-init engine (rf_init_seq) that runs after
// reset and on clr_req. x0 reads as zero, is never busy and ignores writes
// and issues.
//
// Ports
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   rd_addr   in   NREAD*AW   read addresses, port k = [k*AW +: AW]
//   rd_data   out  NREAD*XLEN read data, combinational, port k = [k*XLEN +: XLEN]
//   rd_busy   out  NREAD      addressed register has a pending write
//   wr_en     in   write enable (ignored during INIT)
//   wr_addr   in   AW   write destination
//   wr_data   in   XLEN write data
//   iss_en    in   mark iss_rd pending (ignored during INIT)
//   iss_rd    in   AW   destination being issued
//   clr_req   in   1-cycle pulse: restart re-init
//   ready     out  1 = RUN, file usable
// -----------------------------------------------------------------------------
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int          XLEN    = RF_XLEN,
  parameter int          NREGS   = RF_NREGS,
  parameter int          NREAD   = RF_NREAD,
  parameter int          SP_IDX  = RF_SP_IDX,
  parameter int unsigned SP_INIT = RF_SP_INIT,
  localparam int         AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  clr_req,
  output logic                  ready
);

  logic            init_we;
  logic [AW-1:0]   init_addr;
  logic [XLEN-1:0] init_data;

  rf_init_seq #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .SP_IDX  (SP_IDX),
    .SP_INIT (SP_INIT)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .ready     (ready)
  );

  // Architectural writes are only accepted in RUN and never to x0.
  logic wr_fire;
  logic iss_fire;
  assign wr_fire  = ready && wr_en  && (wr_addr != '0);
  assign iss_fire = ready && iss_en && (iss_rd  != '0);

  // ---------------------------------------------------------------------------
  // Register array: init walk owns the single write port during INIT,
  // writeback owns it during RUN. Contents are deliberately not reset; the
  // init walk is what defines them.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] ru_q [NREGS];

  logic            arr_we;
  logic [AW-1:0]   arr_addr;
  logic [XLEN-1:0] arr_data;

  always_comb begin
    arr_we   = 1'b0;
    arr_addr = wr_addr;
    arr_data = wr_data;
    if (init_we) begin
      arr_we   = 1'b1;
      arr_addr = init_addr;
      arr_data = init_data;
    end else if (wr_fire) begin
      arr_we   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      ru_q[arr_addr] <= arr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard. Writeback clears, issue sets; when both hit the
  // same register in one cycle the issue is applied last so the register
  // stays pending for the newer producer.
  // ---------------------------------------------------------------------------
  logic [NREGS-1:0] sb_q, sb_d;

  always_comb begin
    sb_d = sb_q;
    if (ready) begin
      if (clr_req) begin
        sb_d = '0;
      end else begin
        if (wr_fire) begin
          sb_d[wr_addr] = 1'b0;
        end
        if (iss_fire) begin
          sb_d[iss_rd] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: each resolves independently, so aliased addresses are fine.
  // Outputs are forced quiet during INIT because the array is half-written.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            wr_hit;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr   = rd_addr[k*AW +: AW];
    assign wr_hit = wr_en && (wr_addr == addr);

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (ready && (addr != '0)) begin
        // Same-cycle writeback is forwarded and hides the pending bit it is
        // about to clear.
        data = wr_hit ? wr_data : ru_q[addr];
        busy = sb_q[addr] && !wr_hit;
      end
    end

    assign rd_data[k*XLEN +: XLEN] = data;
    assign rd_busy[k]              = busy;
  end

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
// Directed bench for reg_file_sb with a behavioural model of the file
// (register values, pending set, cycles left before the file becomes usable)
// checked against the outputs every cycle, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  iss_en;
  logic [AW-1:0]         iss_rd;
  logic                  clr_req;
  logic                  ready;

  reg_file_sb dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .clr_req (clr_req),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] m_ru [NREGS];
  logic            m_sb [NREGS];
  logic            m_ready = 1'b0;
  logic            m_valid = 1'b0;
  int              m_rem   = 0;

  function automatic logic [XLEN-1:0] init_val(input int i);
    return (i == 2) ? 32'd1024 : 32'd0;
  endfunction

  // Reset or re-init: the file will hold its init image once it is usable,
  // and nothing is pending; it becomes usable after NREGS more edges.
  always @(posedge clk) begin
    if (!rst_n || (m_ready && clr_req)) begin
      m_valid <= 1'b1;
      m_ready <= 1'b0;
      m_rem   <= NREGS;
      for (int i = 0; i < NREGS; i++) begin
        m_ru[i] <= init_val(i);
        m_sb[i] <= 1'b0;
      end
    end else if (!m_ready) begin
      if (clr_req)         m_rem <= NREGS;
      else if (m_rem == 1) begin m_rem <= 0; m_ready <= 1'b1; end
      else                 m_rem <= m_rem - 1;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_ru[wr_addr] <= wr_data;
        m_sb[wr_addr] <= 1'b0;
      end
      if (iss_en && iss_rd != 0) m_sb[iss_rd] <= 1'b1;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("ready", {31'd0, ready}, {31'd0, m_ready});
      for (int k = 0; k < NREAD; k++) begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] ed;
        logic            eb;
        a  = rd_addr[k*AW +: AW];
        ed = '0;
        eb = 1'b0;
        if (m_ready && a != 0) begin
          if (wr_en && wr_addr == a) ed = wr_data;
          else begin ed = m_ru[a]; eb = m_sb[a]; end
        end
        check($sformatf("rd_data%0d", k), rd_data[k*XLEN +: XLEN], ed);
        check($sformatf("rd_busy%0d", k), {31'd0, rd_busy[k]}, {31'd0, eb});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (ready === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  int n;

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_rd = '0; clr_req = 1'b0;
    tick(); tick();
    settle();
    check("lit_ready_in_reset", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;
    wait_ready(n);
    check("lit_init_cycles", n, 32'd32);

    // Init image
    set_rd(5'd2, 5'd0); settle();
    check("lit_x2_sp", rd_data[31:0], 32'd1024);
    check("lit_x0", rd_data[63:32], 32'd0);
    set_rd(5'd5, 5'd5); settle();
    check("lit_x5", rd_data[31:0], 32'd0);
    tick();

    // Bypass
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; set_rd(5'd5, 5'd2);
    settle();
    check("lit_bypass", rd_data[31:0], 32'hDEADBEEF);
    tick();
    wr_en = 1'b0; settle();
    check("lit_after_write", rd_data[31:0], 32'hDEADBEEF);
    tick();

    // Scoreboard on x7
    iss_en = 1'b1; iss_rd = 5'd7; set_rd(5'd7, 5'd7); settle();
    check("lit_busy_t", {31'd0, rd_busy[0]}, 32'd0);
    tick();
    iss_en = 1'b0; settle();
    check("lit_busy_t1", {31'd0, rd_busy[0]}, 32'd1);
    tick(); tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0077; settle();
    check("lit_busy_t3_bypass", {31'd0, rd_busy[0]}, 32'd0);
    check("lit_data_t3", rd_data[31:0], 32'h77);
    tick();
    wr_en = 1'b0; settle();
    check("lit_busy_t4", {31'd0, rd_busy[1]}, 32'd0);
    tick();

    // Issue and write x9 together: stays busy, data written
    iss_en = 1'b1; iss_rd = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_0009;
    set_rd(5'd3, 5'd4);
    tick();
    iss_en = 1'b0; wr_en = 1'b0; set_rd(5'd9, 5'd9); settle();
    check("lit_x9_busy", {31'd0, rd_busy[1]}, 32'd1);
    check("lit_x9_data", rd_data[31:0], 32'hA5A5_0009);
    tick();

    // x0 protection
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; iss_en = 1'b1; iss_rd = 5'd0;
    set_rd(5'd0, 5'd0); settle();
    check("lit_x0_bypass", rd_data[31:0], 32'd0);
    tick();
    wr_en = 1'b0; iss_en = 1'b0; settle();
    check("lit_x0_data", rd_data[63:32], 32'd0);
    check("lit_x0_busy", {30'd0, rd_busy}, 32'd0);
    tick();

    // clr_req with x3=0x55 and x4 pending, plus a same-cycle write
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; tick();
    wr_en = 1'b0; iss_en = 1'b1; iss_rd = 5'd4; tick();
    iss_en = 1'b0; set_rd(5'd3, 5'd4); settle();
    check("lit_x3_55", rd_data[31:0], 32'h55);
    check("lit_x4_busy", {31'd0, rd_busy[1]}, 32'd1);
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h99;
    tick();
    clr_req = 1'b0; wr_en = 1'b0; settle();
    check("lit_clr_ready", {31'd0, ready}, 32'd0);
    check("lit_init_quiet", rd_data[31:0], 32'd0);
    // Issues and writes during INIT must be dropped
    iss_en = 1'b1; iss_rd = 5'd6; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
    tick();
    iss_en = 1'b0; wr_en = 1'b0;
    wait_ready(n);
    check("lit_reinit_cycles", n, 32'd31);
    settle();
    check("lit_x3_cleared", rd_data[31:0], 32'd0);
    check("lit_x4_idle", {31'd0, rd_busy[1]}, 32'd0);
    set_rd(5'd2, 5'd6); settle();
    check("lit_x2_again", rd_data[31:0], 32'd1024);
    check("lit_x6_dropped", rd_data[63:32], 32'd0);
    check("lit_x6_not_busy", {31'd0, rd_busy[1]}, 32'd0);
    tick();

    // clr_req mid-INIT restarts the walk
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (5) tick();
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    wait_ready(n);
    check("lit_clr_restart", n, 32'd32);
    tick();

    // rst_n pulse mid-INIT restarts the count
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    wait_ready(n);
    check("lit_rst_restart", n, 32'd32);
    set_rd(5'd2, 5'd9); settle();
    check("lit_x9_reinit", rd_data[63:32], 32'd0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_reg_file_sb
